// File: rtl/decode_pkg.sv
// Shared decode definitions: class encodings, default field widths,
// opcode range limits and the decoded-entry layout used by the decode stage.
package decode_pkg;

  localparam int unsigned INSTR_W_DEF   = 16;
  localparam int unsigned OPC_W_DEF     = 6;
  localparam int unsigned REG_SEL_W_DEF = 1;
  localparam int unsigned IMM_W_DEF     = 9;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned NUM_REGS_DEF  = 2 ** REG_SEL_W_DEF;

  localparam int unsigned MEM_LAST_DEF  = 2;
  localparam int unsigned BR_LAST_DEF   = 9;
  localparam int unsigned ALU_LAST_DEF  = 63;

  localparam int unsigned TYPE_W        = 2;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_NOP = 2'b00,
    TYPE_MEM = 2'b01,
    TYPE_BR  = 2'b10,
    TYPE_ALU = 2'b11
  } instr_type_e;

  // Decoded entry at the default field widths.
  typedef struct packed {
    instr_type_e                 itype;
    logic [OPC_W_DEF-1:0]        opcode;
    logic [NUM_REGS_DEF-1:0]     reg_sel;
    logic [IMM_W_DEF-1:0]        addr;
    logic [DATA_W_DEF-1:0]       value;
    logic                        illegal;
  } dec_entry_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Handshake bus of the decode stage: upstream word in, decoded entry out.
// master = fetch/consumer side, slave = the decode stage.
interface instr_decode_stage_if
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W   = INSTR_W_DEF,
  parameter int unsigned OPC_W     = OPC_W_DEF,
  parameter int unsigned REG_SEL_W = REG_SEL_W_DEF,
  parameter int unsigned IMM_W     = IMM_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) ();

  localparam int unsigned NUM_REGS = 2 ** REG_SEL_W;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   in_instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [TYPE_W-1:0]    out_type;
  logic [OPC_W-1:0]     out_opcode;
  logic [NUM_REGS-1:0]  out_reg_sel;
  logic [IMM_W-1:0]     out_addr;
  logic [DATA_W-1:0]    out_value;
  logic                 out_illegal;

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_type, out_opcode, out_reg_sel,
           out_addr, out_value, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_type, out_opcode, out_reg_sel,
           out_addr, out_value, out_illegal
  );

endinterface

// File: rtl/instr_field_decoder.sv
// Combinational instruction-word to decoded-entry mapping.
// Ports: instr in; type_c/opcode_c/reg_sel_c/addr_c/value_c/illegal_c decoded
// fields; nop_c flags opcode 0.
module instr_field_decoder
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W   = INSTR_W_DEF,
  parameter int unsigned OPC_W     = OPC_W_DEF,
  parameter int unsigned REG_SEL_W = REG_SEL_W_DEF,
  parameter int unsigned IMM_W     = IMM_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MEM_LAST  = MEM_LAST_DEF,
  parameter int unsigned BR_LAST   = BR_LAST_DEF,
  parameter int unsigned ALU_LAST  = ALU_LAST_DEF,
  parameter bit          SIGN_EXT  = 1'b0,
  localparam int unsigned NUM_REGS = 2 ** REG_SEL_W
) (
  input  logic [INSTR_W-1:0]  instr,
  output logic [TYPE_W-1:0]   type_c,
  output logic [OPC_W-1:0]    opcode_c,
  output logic [NUM_REGS-1:0] reg_sel_c,
  output logic [IMM_W-1:0]    addr_c,
  output logic [DATA_W-1:0]   value_c,
  output logic                illegal_c,
  output logic                nop_c
);

  logic [OPC_W-1:0]     opc;
  logic [REG_SEL_W-1:0] rsel;
  logic [IMM_W-1:0]     imm;
  logic [31:0]          opc_w;
  logic [DATA_W-1:0]    ext;
  logic [NUM_REGS-1:0]  onehot;

  assign opc    = instr[INSTR_W-1 -: OPC_W];
  assign rsel   = instr[IMM_W +: REG_SEL_W];
  assign imm    = instr[IMM_W-1:0];
  assign opc_w  = 32'(opc);
  assign ext    = SIGN_EXT ? DATA_W'($signed(imm)) : DATA_W'(imm);
  assign onehot = NUM_REGS'(1) << rsel;
  assign nop_c  = (opc_w == 32'd0);

  // Class select by opcode range; unused fields stay zero.
  always_comb begin
    type_c    = TYPE_NOP;
    opcode_c  = '0;
    reg_sel_c = '0;
    addr_c    = '0;
    value_c   = '0;
    illegal_c = 1'b0;
    if (opc_w != 32'd0) begin
      if (opc_w <= MEM_LAST) begin
        type_c    = TYPE_MEM;
        opcode_c  = opc;
        reg_sel_c = onehot;
        value_c   = ext;
      end else if (opc_w <= BR_LAST) begin
        type_c    = TYPE_BR;
        opcode_c  = opc;
        addr_c    = imm;
      end else if (opc_w <= ALU_LAST) begin
        type_c    = TYPE_ALU;
        opcode_c  = OPC_W'(opc_w - BR_LAST);
        reg_sel_c = onehot;
        value_c   = ext;
      end else begin
        type_c    = TYPE_ALU;
        illegal_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Handshaked instruction-decode stage with a 2-entry skid buffer
// (output entry O plus skid entry S), flush and optional NOP dropping.
// Ports: clk, rst (async active-low), ifc (slave side of the decode bus:
// flush, in_valid/in_ready/in_instr, out_valid/out_ready and decoded fields).
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W   = INSTR_W_DEF,
  parameter int unsigned OPC_W     = OPC_W_DEF,
  parameter int unsigned REG_SEL_W = REG_SEL_W_DEF,
  parameter int unsigned IMM_W     = IMM_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MEM_LAST  = MEM_LAST_DEF,
  parameter int unsigned BR_LAST   = BR_LAST_DEF,
  parameter int unsigned ALU_LAST  = ALU_LAST_DEF,
  parameter bit          SIGN_EXT  = 1'b0,
  parameter bit          DROP_NOP  = 1'b1
) (
  input logic               clk,
  input logic               rst,
  instr_decode_stage_if.slave ifc
);

  localparam int unsigned NUM_REGS = 2 ** REG_SEL_W;
  localparam int unsigned ENTRY_W  = TYPE_W + OPC_W + NUM_REGS + IMM_W + DATA_W + 1;

  logic [TYPE_W-1:0]   type_c;
  logic [OPC_W-1:0]    opcode_c;
  logic [NUM_REGS-1:0] reg_sel_c;
  logic [IMM_W-1:0]    addr_c;
  logic [DATA_W-1:0]   value_c;
  logic                illegal_c;
  logic                nop_c;

  logic [ENTRY_W-1:0]  dec_c;
  logic [ENTRY_W-1:0]  o_q, o_d, s_q, s_d;
  logic                o_valid_q, o_valid_d;
  logic                s_valid_q, s_valid_d;
  logic                rdy_q, rdy_d;
  logic                accept_c, emit_c, write_c;

  instr_field_decoder #(
    .INSTR_W   (INSTR_W),
    .OPC_W     (OPC_W),
    .REG_SEL_W (REG_SEL_W),
    .IMM_W     (IMM_W),
    .DATA_W    (DATA_W),
    .MEM_LAST  (MEM_LAST),
    .BR_LAST   (BR_LAST),
    .ALU_LAST  (ALU_LAST),
    .SIGN_EXT  (SIGN_EXT)
  ) u_dec (
    .instr     (ifc.in_instr),
    .type_c    (type_c),
    .opcode_c  (opcode_c),
    .reg_sel_c (reg_sel_c),
    .addr_c    (addr_c),
    .value_c   (value_c),
    .illegal_c (illegal_c),
    .nop_c     (nop_c)
  );

  assign dec_c    = {type_c, opcode_c, reg_sel_c, addr_c, value_c, illegal_c};
  assign accept_c = ifc.in_valid && rdy_q;
  assign emit_c   = o_valid_q && ifc.out_ready;
  // A dropped NOP is still consumed but never occupies an entry.
  assign write_c  = accept_c && !(DROP_NOP && nop_c);

  // Skid-buffer next state; flush wins over accept and emit.
  always_comb begin
    o_d       = o_q;
    s_d       = s_q;
    o_valid_d = o_valid_q;
    s_valid_d = s_valid_q;
    if (ifc.flush) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (emit_c || !o_valid_q) begin
      if (s_valid_q) begin
        // in_ready was low, so no accept can coincide with the S->O move.
        o_d       = s_q;
        o_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else begin
        o_valid_d = write_c;
        if (write_c) begin
          o_d = dec_c;
        end
      end
    end else if (write_c) begin
      s_d       = dec_c;
      s_valid_d = 1'b1;
    end
    rdy_d = !s_valid_d;
  end

  // State registers; in_ready is its own flop so it stays low through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_q       <= '0;
      s_q       <= '0;
      o_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      o_q       <= o_d;
      s_q       <= s_d;
      o_valid_q <= o_valid_d;
      s_valid_q <= s_valid_d;
      rdy_q     <= rdy_d;
    end
  end

  assign ifc.in_ready  = rdy_q;
  assign ifc.out_valid = o_valid_q;
  assign {ifc.out_type, ifc.out_opcode, ifc.out_reg_sel,
          ifc.out_addr, ifc.out_value, ifc.out_illegal} = o_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage. Four instances share one stimulus
// stream: 0 default, 1 SIGN_EXT=1, 2 ALU_LAST=20, 3 DROP_NOP=0.
module tb_instr_decode_stage;
  import decode_pkg::*;

  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] in_instr = '0;

  logic [NDUT-1:0] rdy_v;
  logic [NDUT-1:0] ov_v;
  dec_entry_t [NDUT-1:0] act_v;

  dec_entry_t exp_q [NDUT][$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gd
    instr_decode_stage_if ifc ();

    instr_decode_stage #(
      .ALU_LAST (g == 2 ? 20 : 63),
      .SIGN_EXT (1'(g == 1)),
      .DROP_NOP (1'(g != 3))
    ) dut (
      .clk (clk),
      .rst (rst),
      .ifc (ifc.slave)
    );

    assign ifc.in_valid  = in_valid;
    assign ifc.in_instr  = in_instr;
    assign ifc.out_ready = out_ready;
    assign ifc.flush     = flush;
    assign rdy_v[g]      = ifc.in_ready;
    assign ov_v[g]       = ifc.out_valid;
    assign act_v[g]      = {ifc.out_type, ifc.out_opcode, ifc.out_reg_sel,
                            ifc.out_addr, ifc.out_value, ifc.out_illegal};
  end

  // Reference decode from the opcode-range rules, using plain arithmetic.
  function automatic void ref_decode(input logic [15:0] w, input int g,
                                     output dec_entry_t e, output bit keep);
    int opc, r, imm, alu_last, val;
    bit se, dn;
    se       = (g == 1);
    alu_last = (g == 2) ? 20 : 63;
    dn       = (g != 3);
    opc = int'(w) / 1024;
    r   = (int'(w) / 512) % 2;
    imm = int'(w) % 512;
    val = (se && imm >= 256) ? imm + 65536 - 512 : imm;
    e    = '0;
    keep = 1'b1;
    if (opc == 0) begin
      keep = !dn;
    end else if (opc <= 2) begin
      e.itype = TYPE_MEM; e.opcode = 6'(opc); e.reg_sel = 2'(1 << r); e.value = 16'(val);
    end else if (opc <= 9) begin
      e.itype = TYPE_BR; e.opcode = 6'(opc); e.addr = 9'(imm);
    end else if (opc <= alu_last) begin
      e.itype = TYPE_ALU; e.opcode = 6'(opc - 9); e.reg_sel = 2'(1 << r); e.value = 16'(val);
    end else begin
      e.itype = TYPE_ALU; e.illegal = 1'b1;
    end
  endfunction

  function automatic dec_entry_t mk(input instr_type_e t, input int op, input int rs,
                                    input int ad, input int v, input bit il);
    dec_entry_t e;
    e.itype = t; e.opcode = 6'(op); e.reg_sel = 2'(rs);
    e.addr = 9'(ad); e.value = 16'(v); e.illegal = il;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side: every accepted word pushes its expected entry.
  always @(negedge clk) begin : model_push
    dec_entry_t e;
    bit keep;
    for (int g = 0; g < NDUT; g++) begin
      if (!rst || flush) begin
        exp_q[g].delete();
      end else if (in_valid && rdy_v[g]) begin
        ref_decode(in_instr, g, e, keep);
        if (keep) exp_q[g].push_back(e);
      end
    end
  end

  // Monitor side: every emitted entry pops and compares.
  always @(negedge clk) begin : monitor
    dec_entry_t e;
    for (int g = 0; g < NDUT; g++) begin
      if (rst && !flush && ov_v[g] && out_ready) begin
        if (exp_q[g].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut%0d_unexpected_out: got %0h expected none", g, act_v[g]);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("dut%0d_out", g), 64'(act_v[g]), 64'(e));
        end
      end
    end
  end

  task automatic send(input logic [15:0] w);
    in_valid = 1'b1;
    in_instr = w;
    step();
  endtask

  logic [15:0] wv [3];
  logic [15:0] w;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_out_valid", 64'(ov_v), 64'(0));
    chk("rst_in_ready", 64'(rdy_v), 64'(0));
    chk("rst_fields", 64'(act_v[0]), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(rdy_v), 64'hF);

    // Directed decode, out_ready high, back-to-back words
    out_ready = 1'b1;
    send(16'h0801);
    chk("mem_decode", 64'(act_v[0]), 64'(mk(TYPE_MEM, 2, 1, 0, 1, 0)));
    send(16'h0C02);
    chk("br_decode", 64'(act_v[0]), 64'(mk(TYPE_BR, 3, 0, 2, 0, 0)));
    send(16'h2A03);
    chk("alu_decode", 64'(act_v[0]), 64'(mk(TYPE_ALU, 1, 2, 0, 3, 0)));
    send(16'h05FF);
    chk("zero_ext", 64'(act_v[0].value), 64'(16'h01FF));
    chk("sign_ext", 64'(act_v[1].value), 64'(16'hFFFF));
    send(16'h5405);
    chk("illegal_decode", 64'(act_v[2]), 64'(mk(TYPE_ALU, 0, 0, 0, 0, 1)));
    chk("op21_legal", 64'(act_v[0]), 64'(mk(TYPE_ALU, 12, 1, 0, 5, 0)));
    send(16'h0000);
    chk("nop_dropped", 64'(ov_v[0]), 64'(0));
    chk("nop_kept_valid", 64'(ov_v[3]), 64'(1));
    chk("nop_kept_fields", 64'(act_v[3]), 64'(0));
    in_valid = 1'b0;
    step();

    // Back-pressure: two words buffered, third refused, then drained in order
    for (int i = 0; i < 3; i++) wv[i] = 16'(((i + 3) << 10) | $urandom_range(0, 1023));
    out_ready = 1'b0;
    send(wv[0]);
    send(wv[1]);
    in_valid = 1'b1;
    in_instr = wv[2];
    chk("bp_third_in_ready", 64'(rdy_v[0]), 64'(0));
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_first_valid", 64'(ov_v[0]), 64'(1));
    chk("bp_first_addr", 64'(act_v[0].addr), 64'(wv[0] % 16'd512));
    step();
    chk("bp_second_valid", 64'(ov_v[0]), 64'(1));
    chk("bp_second_addr", 64'(act_v[0].addr), 64'(wv[1] % 16'd512));
    chk("bp_in_ready_back", 64'(rdy_v[0]), 64'(1));
    step();
    chk("bp_drained", 64'(ov_v[0]), 64'(0));

    // Flush with both entries full and a word offered in the flush cycle
    out_ready = 1'b0;
    send(16'h0C11);
    send(16'h0E22);
    in_valid = 1'b1;
    in_instr = 16'h1033;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(ov_v), 64'(0));
    chk("flush_in_ready", 64'(rdy_v), 64'hF);
    out_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic
    repeat (1500) begin
      w = 16'($urandom);
      if ($urandom_range(0, 7) == 0) w = w & 16'h03FF;
      in_instr  = w;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("dut%0d_leftover", g), 64'(exp_q[g].size()), 64'(0));

    // Reset in the middle of a transfer
    out_ready = 1'b0;
    send(16'h0C44);
    send(16'h0C55);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov_v), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();
    chk("midrst_no_output", 64'(ov_v), 64'(0));
    chk("midrst_in_ready", 64'(rdy_v), 64'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
